dm_store_unit: RTL and testbench



---
 rtl/dm_store_unit_pkg.sv | 35 +++
 rtl/dm_store_unit_fsm.sv | 91 +++++++++
 rtl/dm_store_unit.sv | 110 +++++++++++
 tb/tb_dm_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_store_unit_pkg.sv
// Shared store-side definitions: DM control codes, exception code, timer
// register offsets and the device-store FSM state type.
package dm_store_unit_pkg;

  localparam int DATA_W = 32;

  // DM control codes for stores, next to the load codes
  // (DM_LW..DM_LHU occupy 0..4).
  localparam logic [3:0] DM_SB = 4'd5;
  localparam logic [3:0] DM_SH = 4'd6;
  localparam logic [3:0] DM_SW = 4'd7;

  // Store address exception code reported through CP0.
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Timer register byte offsets inside a device window.
  localparam logic [3:0] TMR_CTRL   = 4'h0;
  localparam logic [3:0] TMR_PRESET = 4'h4;
  localparam logic [3:0] TMR_COUNT  = 4'h8;

  // Each timer exposes three 32-bit registers.
  localparam logic [31:0] DEV_SPAN = 32'd12;

  typedef enum logic [1:0] {
    DEV_IDLE = 2'd0,
    DEV_REQ  = 2'd1,
    DEV_DONE = 2'd2
  } devState_e;

  // True when addr lies inside the three-word window starting at base.
  function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && ((addr - base) < DEV_SPAN);
  endfunction

endpackage

// File: rtl/dm_store_unit_fsm.sv
// Device write handshake: latches the word address/data, holds the request
// until the bridge acks or the wait budget runs out, then spends one masking
// cycle before returning to idle.
module dev_store_fsm
  import dm_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              idle,
  output logic              busy,
  output logic              stallReq,
  output logic              devReq,
  output logic              busErr,
  output logic [DATA_W-1:0] devAddr,
  output logic [DATA_W-1:0] devData
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  devState_e         state;
  devState_e         stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic              timeout;

  assign timeout = (cnt == CNT_LAST);

  // State register; reset drops any pending request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DEV_IDLE;
    else       state <= stateNext;
  end

  // Next state: the request ends on ack or when the wait budget is spent.
  always_comb begin
    stateNext = state;
    unique case (state)
      DEV_IDLE: if (start) stateNext = DEV_REQ;
      DEV_REQ:  if (ack || timeout) stateNext = DEV_DONE;
      DEV_DONE: stateNext = DEV_IDLE;
      default:  stateNext = DEV_IDLE;
    endcase
  end

  // Outputs: only REQ drives the bus; stall is released in the closing cycle.
  always_comb begin
    idle     = 1'b0;
    busy     = 1'b0;
    stallReq = 1'b0;
    devReq   = 1'b0;
    busErr   = 1'b0;
    devAddr  = '0;
    devData  = '0;
    unique case (state)
      DEV_IDLE: idle = 1'b1;
      DEV_REQ: begin
        busy     = 1'b1;
        devReq   = 1'b1;
        devAddr  = addrQ;
        devData  = dataQ;
        stallReq = ~(ack | timeout);
        busErr   = ~ack & timeout;
      end
      default: ;
    endcase
  end

  // Wait counter and request latches; inputs are sampled only on issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      addrQ <= '0;
      dataQ <= '0;
    end else if ((state == DEV_IDLE) && start) begin
      cnt   <= '0;
      addrQ <= addr;
      dataQ <= data;
    end else if (state == DEV_REQ) begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm_store_unit.sv
// MEM-stage store unit: byte-lane alignment for data memory, AdES detection,
// and the stall-protected word write path to the timer devices.
module dm_store_unit
  import dm_store_unit_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT    = 32'h0000_3000,
  parameter logic [31:0] DEV0_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE   = 32'h0000_7f10,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iValid,
  input  logic [3:0]        ictrl,
  input  logic [DATA_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDEV_Ack,
  output logic              oDM_WE,
  output logic [3:0]        oDM_BE,
  output logic [DATA_W-1:0] oDM_Data,
  output logic              oDEV_Req,
  output logic [DATA_W-1:0] oDEV_Addr,
  output logic [DATA_W-1:0] oDEV_Data,
  output logic              oStall,
  output logic              oEXC,
  output logic              oBusErr
);

  logic              isSb, isSh, isSw, isLive;
  logic              inDm, inDev0, inDev1, inDev;
  logic [3:0]        devOff;
  logic              misAlign, isCount, isExc;
  logic [3:0]        laneBe;
  logic [DATA_W-1:0] laneData;
  logic              fsmIdle, fsmBusy, reqStall, start;

  // Decode the store, its target region and every AdES cause.
  always_comb begin
    isSb     = (ictrl == DM_SB);
    isSh     = (ictrl == DM_SH);
    isSw     = (ictrl == DM_SW);
    isLive   = iValid & (isSb | isSh | isSw);
    inDm     = (iAddr < DM_LIMIT);
    inDev0   = inWindow(iAddr, DEV0_BASE);
    inDev1   = inWindow(iAddr, DEV1_BASE);
    inDev    = inDev0 | inDev1;
    // Windows sit on 16-byte boundaries, so the low nibble is the offset.
    devOff   = iAddr[3:0] - (inDev1 ? DEV1_BASE[3:0] : DEV0_BASE[3:0]);
    misAlign = (isSh & iAddr[0]) | (isSw & (iAddr[1:0] != 2'b00));
    isCount  = inDev & (devOff >= TMR_COUNT);
    isExc    = misAlign | (inDev & ~isSw) | isCount | (~inDm & ~inDev);
  end

  // Replicate the store data into every lane and pick the enabled bytes.
  always_comb begin
    if (isSb) begin
      laneBe   = 4'b0001 << iAddr[1:0];
      laneData = {4{iData[7:0]}};
    end else if (isSh) begin
      laneBe   = iAddr[1] ? 4'b1100 : 4'b0011;
      laneData = {2{iData[15:0]}};
    end else begin
      laneBe   = 4'b1111;
      laneData = iData;
    end
  end

  // Route a live store: exception, DM write, or device handshake start.
  always_comb begin
    oDM_WE   = 1'b0;
    oDM_BE   = '0;
    oDM_Data = '0;
    oStall   = 1'b0;
    oEXC     = 1'b0;
    start    = 1'b0;
    if (!reset && fsmIdle && isLive) begin
      if (isExc) begin
        oEXC = 1'b1;
      end else if (inDm) begin
        oDM_WE   = 1'b1;
        oDM_BE   = laneBe;
        oDM_Data = laneData;
      end else begin
        oStall = 1'b1;
        start  = 1'b1;
      end
    end else if (!reset && fsmBusy) begin
      oStall = reqStall;
    end
  end

  dev_store_fsm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) uFsm (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ack     (iDEV_Ack),
    .addr    ({iAddr[31:2], 2'b00}),
    .data    (iData),
    .idle    (fsmIdle),
    .busy    (fsmBusy),
    .stallReq(reqStall),
    .devReq  (oDEV_Req),
    .busErr  (oBusErr),
    .devAddr (oDEV_Addr),
    .devData (oDEV_Data)
  );

endmodule

// File: tb/tb_dm_store_unit.sv
// Directed plus randomized bench for dm_store_unit with a behavioural
// reference for store routing and the device handshake timeline.
module tb_dm_store_unit;
  import dm_store_unit_pkg::*;

  localparam int ACK_TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        iValid;
  logic [3:0]  ictrl;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic        iDEV_Ack;
  logic        oDM_WE;
  logic [3:0]  oDM_BE;
  logic [31:0] oDM_Data;
  logic        oDEV_Req;
  logic [31:0] oDEV_Addr;
  logic [31:0] oDEV_Data;
  logic        oStall;
  logic        oEXC;
  logic        oBusErr;

  int nAssert = 0;
  int nFail   = 0;

  dm_store_unit dut (
    .clk      (clk),
    .reset    (reset),
    .iValid   (iValid),
    .ictrl    (ictrl),
    .iAddr    (iAddr),
    .iData    (iData),
    .iDEV_Ack (iDEV_Ack),
    .oDM_WE   (oDM_WE),
    .oDM_BE   (oDM_BE),
    .oDM_Data (oDM_Data),
    .oDEV_Req (oDEV_Req),
    .oDEV_Addr(oDEV_Addr),
    .oDEV_Data(oDEV_Data),
    .oStall   (oStall),
    .oEXC     (oEXC),
    .oBusErr  (oBusErr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic req, input logic stall,
                           input logic exc, input logic berr);
    chk({tag, ".we"},    32'(oDM_WE),   32'(we));
    chk({tag, ".be"},    32'(oDM_BE),   32'(be));
    chk({tag, ".data"},  oDM_Data,      wd);
    chk({tag, ".req"},   32'(oDEV_Req), 32'(req));
    chk({tag, ".stall"}, 32'(oStall),   32'(stall));
    chk({tag, ".exc"},   32'(oEXC),     32'(exc));
    chk({tag, ".berr"},  32'(oBusErr),  32'(berr));
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    iValid = v;
    ictrl  = c;
    iAddr  = a;
    iData  = d;
  endtask

  // Reference: what a store does, derived from sizes and address ranges.
  function automatic void refStore(input logic [3:0] c, input logic v, input logic [31:0] a,
                                   input logic [31:0] d, output logic we, output logic [3:0] be,
                                   output logic [31:0] wd, output logic exc, output logic dev);
    int  size, lo;
    bit  isDm, isDev;
    we = 1'b0; be = '0; wd = '0; exc = 1'b0; dev = 1'b0;
    size = (c == DM_SB) ? 1 : (c == DM_SH) ? 2 : (c == DM_SW) ? 4 : 0;
    if (!v || size == 0) return;
    isDm  = a < 32'h3000;
    isDev = (a >= 32'h7f00 && a < 32'h7f0c) || (a >= 32'h7f10 && a < 32'h7f1c);
    lo    = int'(a[1:0]);
    exc   = (lo % size != 0) || !(isDm || isDev) || (isDev && size != 4)
            || (isDev && int'(a[3:0]) >= 8);
    if (exc) return;
    if (isDev) begin
      dev = 1'b1;
      return;
    end
    we = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + size) be[b] = 1'b1;
      wd[8*b +: 8] = d[8*(b % size) +: 8];
    end
  endfunction

  // Follows an issued device store: ackAt is the REQ cycle carrying the ack
  // (beyond ACK_TO means none). mode 0 holds inputs, 1 flushes, 2 scrambles.
  task automatic runDev(input string tag, input int ackAt, input logic [31:0] expAddr,
                        input logic [31:0] expData, input int mode);
    for (int k = 1; k <= ACK_TO; k++) begin
      step();
      iDEV_Ack = (k == ackAt);
      if (mode == 1) iValid = 1'b0;
      if (mode == 2) drive(1'($urandom), 4'($urandom), $urandom, $urandom);
      #1;
      chk({tag, ".req"},   32'(oDEV_Req), 32'd1);
      chk({tag, ".addr"},  oDEV_Addr,     expAddr);
      chk({tag, ".ddata"}, oDEV_Data,     expData);
      chk({tag, ".stall"}, 32'(oStall),   32'((k != ackAt) && (k != ACK_TO)));
      chk({tag, ".berr"},  32'(oBusErr),  32'((k == ACK_TO) && (k != ackAt)));
      chk({tag, ".noexc"}, 32'(oEXC),     32'd0);
      if (k == ackAt || k == ACK_TO) break;
    end
    step();
    iDEV_Ack = 1'($urandom);
    #1;
    expectOut({tag, ".done"}, 0, 4'h0, 32'h0, 0, 0, 0, 0);
    chk({tag, ".doneAddr"}, oDEV_Addr, 32'h0);
    iDEV_Ack = 1'b0;
  endtask

  logic [31:0] excAddr [3] = '{32'h7f18, 32'h7f10, 32'h4000};
  logic [3:0]  excCtrl [3] = '{DM_SW, DM_SB, DM_SW};

  initial begin
    logic        we, exc, dev, v;
    logic [3:0]  be, c;
    logic [31:0] wd, a, d;

    // Reset holds every output low, even with a live store presented.
    reset = 1'b1;
    iDEV_Ack = 1'b0;
    drive(1, DM_SW, 32'h0000_0100, 32'h1111_2222);
    #2;
    expectOut("reset", 0, 4'h0, 32'h0, 0, 0, 0, 0);
    chk("reset.addr", oDEV_Addr, 32'h0);
    step();
    step();
    reset = 1'b0;
    drive(0, DM_SW, 32'h0, 32'h0);
    #1;
    expectOut("postReset", 0, 4'h0, 32'h0, 0, 0, 0, 0);

    step();
    drive(1, DM_SB, 32'h1003, 32'h0000_00A5);
    #1;
    expectOut("sb1003", 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 0, 0);

    step();
    drive(1, DM_SH, 32'h0002, 32'h0000_1234);
    #1;
    expectOut("sh0002", 1, 4'b1100, 32'h1234_1234, 0, 0, 0, 0);
    step();
    drive(1, DM_SH, 32'h0001, 32'h0000_1234);
    #1;
    expectOut("sh0001", 0, 4'h0, 32'h0, 0, 0, 1, 0);

    // Timer write acked in the third REQ cycle.
    step();
    drive(1, DM_SW, 32'h7f04, 32'hDEAD_0000);
    #1;
    expectOut("sw7f04.detect", 0, 4'h0, 32'h0, 0, 1, 0, 0);
    runDev("sw7f04", 3, 32'h7f04, 32'hDEAD_0000, 0);
    step();
    drive(0, DM_SW, 32'h0, 32'h0);
    #1;
    expectOut("sw7f04.idle", 0, 4'h0, 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, excCtrl[i], excAddr[i], 32'hCAFE_F00D);
      #1;
      expectOut($sformatf("ades%0d", i), 0, 4'h0, 32'h0, 0, 0, 1, 0);
      step();
      #1;
      expectOut($sformatf("ades%0d.next", i), 0, 4'h0, 32'h0, 0, 0, 1, 0);
    end

    // No ack, instruction flushed while waiting: still runs to the timeout.
    step();
    drive(1, DM_SW, 32'h7f14, 32'h0BAD_BEEF);
    #1;
    expectOut("sw7f14.detect", 0, 4'h0, 32'h0, 0, 1, 0, 0);
    runDev("sw7f14", ACK_TO + 1, 32'h7f14, 32'h0BAD_BEEF, 1);
    step();
    #1;
    expectOut("sw7f14.idle", 0, 4'h0, 32'h0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a request.
    step();
    drive(1, DM_SW, 32'h7f00, 32'h1357_9BDF);
    #1;
    step();
    #1;
    chk("rstReq.before", 32'(oDEV_Req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstReq.req",   32'(oDEV_Req), 32'd0);
    chk("rstReq.stall", 32'(oStall),   32'd0);
    chk("rstReq.addr",  oDEV_Addr,     32'h0);
    step();
    reset = 1'b0;
    drive(0, DM_SW, 32'h0, 32'h0);
    #1;
    expectOut("rstReq.idle", 0, 4'h0, 32'h0, 0, 0, 0, 0);
    step();
    drive(1, DM_SW, 32'h7f00, 32'h2468_ACE0);
    #1;
    expectOut("sw7f00.detect", 0, 4'h0, 32'h0, 0, 1, 0, 0);
    runDev("sw7f00", 2, 32'h7f00, 32'h2468_ACE0, 0);

    // Randomized stores against the reference.
    for (int n = 0; n < 150; n++) begin
      step();
      case ($urandom_range(0, 4))
        0: c = DM_SB;
        1: c = DM_SH;
        2, 3: c = DM_SW;
        default: c = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 32'h2fff);
        1: a = 32'h7f00 + $urandom_range(0, 15);
        2: a = 32'h7f10 + $urandom_range(0, 15);
        3: a = $urandom;
        default: a = 32'h2ff8 + $urandom_range(0, 15);
      endcase
      v = ($urandom_range(0, 7) != 0);
      d = $urandom;
      drive(v, c, a, d);
      iDEV_Ack = 1'($urandom);
      #1;
      refStore(c, v, a, d, we, be, wd, exc, dev);
      expectOut($sformatf("rnd%0d", n), we, be, wd, 0, dev, exc, 0);
      iDEV_Ack = 1'b0;
      if (dev) runDev($sformatf("rnd%0d.dev", n), $urandom_range(1, ACK_TO + 1),
                      {a[31:2], 2'b00}, d, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
